data_mem_ctrl: RTL

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_pkg.sv | 33 +++
 rtl/data_mem_array.sv | 40 ++++
 rtl/data_mem_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory controller: FSM states, error reasons,
// word-index sizing and byte-enable legality (used when DATA_MEM_CTRL_BYTE_LANES_EN is set).
package data_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;

  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

  // Legal lane masks are non-zero and form one contiguous run of bytes.
  function automatic logic be_contig(input logic [3:0] be);
    logic ok;
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b0110, 4'b1100,
      4'b0111, 4'b1110,
      4'b1111: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port word RAM: synchronous write with byte enables, registered read
// (data appears the cycle after re). Only the read register is reset; contents persist.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = idx_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Processor data-memory controller: one request at a time, 2-cycle load/store latency, response
// held until rsp_ready. DATA_MEM_CTRL_BYTE_LANES_EN adds req_be byte-lane stores.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
`ifdef DATA_MEM_CTRL_BYTE_LANES_EN
  input  logic [3:0]       req_be,
`endif
  output logic             req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  output logic [7:0]       err_count
);

  localparam int IDX_W = idx_width(DEPTH);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic             write_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic             rd_sel_q;

  logic [CNT_W-1:0] rd_count_q, rd_count_d;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;
  logic [7:0]       err_count_q, err_count_d;

  logic [3:0]  be_in;
  logic        misalign;
  logic [1:0]  err_rsn;
  logic [31:0] ram_rdata;
  logic        rsp_hs;

  // Range is checked on the full word index so high address bits cannot alias into the array.
  always_comb begin
    be_in    = 4'hF;
    misalign = |req_addr[1:0];
`ifdef DATA_MEM_CTRL_BYTE_LANES_EN
    be_in    = req_be;
    misalign = !be_contig(req_be);
`endif
    err_rsn = ERR_NONE;
    if (|req_addr[31:IDX_W+2]) begin
      err_rsn = ERR_RANGE;
    end else if (misalign) begin
      err_rsn = ERR_ALIGN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      write_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            idx_q   <= req_addr[IDX_W+1:2];
            wdata_q <= req_wdata;
            be_q    <= be_in;
            write_q <= req_write;
            if (err_rsn != ERR_NONE) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rd_sel_q    <= 1'b0;
            end else if (req_write) begin
              state_q <= ST_WRITE;
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rd_sel_q    <= 1'b1;
        end
        ST_WRITE: begin
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rd_sel_q    <= 1'b0;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_sel_q    <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  data_mem_array #(
    .DEPTH (DEPTH),
    .AW    (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (state_q == ST_WRITE),
    .re    (state_q == ST_READ),
    .addr  (idx_q),
    .wdata (wdata_q),
    .be    (be_q),
    .rdata (ram_rdata)
  );

  assign rsp_hs = rsp_valid_q && rsp_ready;

  always_comb begin
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    err_count_d = err_count_q;
    if (rsp_hs) begin
      if (rsp_err_q) begin
        if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
      end else if (write_q) begin
        if (wr_count_q != '1) wr_count_d = wr_count_q + CNT_W'(1);
      end else begin
        if (rd_count_q != '1) rd_count_d = rd_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      err_count_q <= err_count_d;
    end
  end

  // The RAM read register only moves in READ, so load data stays put while RESP stalls.
  assign rsp_rdata = rd_sel_q ? ram_rdata : 32'h0;
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;
  assign err_count = err_count_q;

endmodule
